// File: rtl/prescaled_bcd_counter.sv
// Prescaled packed-BCD up counter with binary mirror, sticky overflow and a high-score register.
// Counts prescaled ticks plus external bumps; saturates or wraps at 10^DIGITS-1.
module prescaled_bcd_counter #(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned PRESCALE        = 15,
  parameter int unsigned PRE_W           = 13,
  parameter int unsigned BIN_W           = 32,
  parameter int unsigned HOLD_ON_DISABLE = 0,
  parameter int unsigned SATURATE        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  bump,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      bin,
  output logic                  tick,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   best,
  output logic                  new_best
);

  localparam int unsigned CW = 4 * DIGITS;

  function automatic longint unsigned pow10(input int unsigned d);
    longint unsigned v;
    v = 1;
    for (int unsigned i = 0; i < d; i++) v = v * 10;
    return v;
  endfunction

  localparam longint unsigned MAXV     = pow10(DIGITS) - 1;
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAXV);
  localparam logic [CW-1:0]    MAX_BCD = {DIGITS{4'd9}};
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_q;
  logic [CW-1:0]    bcd_q;
  logic [BIN_W-1:0] bin_q;
  logic             tick_q;
  logic             ovf_q;
  logic [CW-1:0]    best_q;
  logic             new_best_q;

  logic             tick_ev;
  logic [1:0]       n;
  logic [1:0]       cin;
  logic [4:0]       dsum;
  logic [CW-1:0]    bcd_sum;
  logic             bcd_cout;
  logic [BIN_W:0]   bin_sum;
  logic             bin_over;
  logic [CW-1:0]    bcd_next;
  logic [BIN_W-1:0] bin_next;
  logic             ovf_hit;

  assign tick_ev = en & (pre_q == '0);
  assign n       = {1'b0, tick_ev} + {1'b0, bump & en};

  // Digit-wise ripple add; digit 0 takes the full 0..2 increment, the rest a 0/1 carry.
  always_comb begin
    bcd_sum = '0;
    cin     = n;
    dsum    = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dsum = {1'b0, bcd_q[4*i +: 4]} + {3'b000, cin};
      if (dsum >= 5'd10) begin
        bcd_sum[4*i +: 4] = 4'(dsum - 5'd10);
        cin               = 2'd1;
      end else begin
        bcd_sum[4*i +: 4] = dsum[3:0];
        cin               = 2'd0;
      end
    end
    bcd_cout = cin[0];
  end

  assign bin_sum  = {1'b0, bin_q} + (BIN_W+1)'(n);
  assign bin_over = bin_sum > {1'b0, MAX_BIN};

  // A carry out of the top digit means count+n exceeded M, for clamping and wrapping alike.
  always_comb begin
    bcd_next = bcd_sum;
    bin_next = bin_sum[BIN_W-1:0];
    ovf_hit  = 1'b0;
    if (SATURATE != 0) begin
      if (bcd_cout) bcd_next = MAX_BCD;
      if (bin_over) bin_next = MAX_BIN;
      ovf_hit = (bcd_next == MAX_BCD);
    end else begin
      if (bin_over) bin_next = BIN_W'(bin_sum - {1'b0, MAX_BIN} - (BIN_W+1)'(1));
      ovf_hit = bcd_cout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q  <= '0;
      bcd_q  <= '0;
      bin_q  <= '0;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (clr) begin
      pre_q  <= '0;
      bcd_q  <= '0;
      bin_q  <= '0;
      tick_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (en) begin
      pre_q  <= (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
      bcd_q  <= bcd_next;
      bin_q  <= bin_next;
      tick_q <= tick_ev;
      if (ovf_hit) ovf_q <= 1'b1;
    end else begin
      tick_q <= 1'b0;
      if (HOLD_ON_DISABLE == 0) begin
        pre_q <= '0;
        bcd_q <= '0;
        bin_q <= '0;
      end
    end
  end

  // Packed BCD orders the same as its decimal value, so a plain compare suffices.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_q     <= '0;
      new_best_q <= 1'b0;
    end else if (bcd_q > best_q) begin
      best_q     <= bcd_q;
      new_best_q <= 1'b1;
    end else begin
      new_best_q <= 1'b0;
    end
  end

  assign bcd      = bcd_q;
  assign bin      = bin_q;
  assign tick     = tick_q;
  assign ovf      = ovf_q;
  assign best     = best_q;
  assign new_best = new_best_q;

endmodule

// File: tb/tb_prescaled_bcd_counter.sv
// Bench for prescaled_bcd_counter: three parameterisations driven in lockstep,
// each checked every cycle against an integer-valued reference model.
module tb_prescaled_bcd_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, clr = 1'b0, bump = 1'b0;

  always #5 clk = ~clk;

  logic [15:0] bcd_a, best_a;  logic [31:0] bin_a;  logic tick_a, ovf_a, nb_a;
  logic [7:0]  bcd_b, best_b;  logic [7:0]  bin_b;  logic tick_b, ovf_b, nb_b;
  logic [7:0]  bcd_c, best_c;  logic [6:0]  bin_c;  logic tick_c, ovf_c, nb_c;

  prescaled_bcd_counter #(.DIGITS(4), .PRESCALE(15), .PRE_W(13), .BIN_W(32),
                          .HOLD_ON_DISABLE(0), .SATURATE(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .bump(bump),
    .bcd(bcd_a), .bin(bin_a), .tick(tick_a), .ovf(ovf_a), .best(best_a), .new_best(nb_a));

  prescaled_bcd_counter #(.DIGITS(2), .PRESCALE(3), .PRE_W(2), .BIN_W(8),
                          .HOLD_ON_DISABLE(1), .SATURATE(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .bump(bump),
    .bcd(bcd_b), .bin(bin_b), .tick(tick_b), .ovf(ovf_b), .best(best_b), .new_best(nb_b));

  prescaled_bcd_counter #(.DIGITS(2), .PRESCALE(1), .PRE_W(1), .BIN_W(7),
                          .HOLD_ON_DISABLE(0), .SATURATE(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .bump(bump),
    .bcd(bcd_c), .bin(bin_c), .tick(tick_c), .ovf(ovf_c), .best(best_c), .new_best(nb_c));

  int n_cmp = 0;
  int n_bad = 0;
  int tick_cnt_a = 0;

  int digs [3] = '{4, 2, 2};
  int ps   [3] = '{15, 3, 1};
  int hold [3] = '{0, 1, 0};
  int sat  [3] = '{1, 0, 1};

  int pre_m [3];
  int cnt_m [3];
  int best_m[3];
  bit tick_m[3];
  bit ovf_m [3];
  bit nb_m  [3];

  function automatic logic [63:0] to_bcd(input int v);
    logic [63:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int maxv(input int d);
    int v;
    v = 1;
    for (int i = 0; i < d; i++) v = v * 10;
    return v - 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      pre_m[k] = 0; cnt_m[k] = 0; best_m[k] = 0;
      tick_m[k] = 0; ovf_m[k] = 0; nb_m[k] = 0;
    end
  endtask

  // One clock edge of the specified behaviour, using the inputs held over the edge.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int m, old, s;
      bit tev;
      m   = maxv(digs[k]);
      old = cnt_m[k];
      if (old > best_m[k]) begin
        best_m[k] = old;
        nb_m[k]   = 1;
      end else begin
        nb_m[k] = 0;
      end
      if (clr) begin
        pre_m[k] = 0; cnt_m[k] = 0; ovf_m[k] = 0; tick_m[k] = 0;
      end else if (en) begin
        tev = (pre_m[k] == 0);
        s   = old + int'(tev) + int'(bump);
        if (sat[k] != 0) begin
          if (s >= m) begin
            cnt_m[k] = m;
            ovf_m[k] = 1;
          end else begin
            cnt_m[k] = s;
          end
        end else if (s > m) begin
          cnt_m[k] = s - (m + 1);
          ovf_m[k] = 1;
        end else begin
          cnt_m[k] = s;
        end
        pre_m[k]  = (pre_m[k] + 1) % ps[k];
        tick_m[k] = tev;
      end else begin
        tick_m[k] = 0;
        if (hold[k] == 0) begin
          pre_m[k] = 0;
          cnt_m[k] = 0;
        end
      end
    end
  endtask

  task automatic check_inst(input int k, input string nm, input logic [63:0] b,
                            input logic [63:0] bn, input logic [63:0] bs,
                            input logic tk, input logic ov, input logic nb);
    check({nm, ".bcd"},      b,  to_bcd(cnt_m[k]));
    check({nm, ".bin"},      bn, 64'(cnt_m[k]));
    check({nm, ".best"},     bs, to_bcd(best_m[k]));
    check({nm, ".tick"},     64'(tk), 64'(tick_m[k]));
    check({nm, ".ovf"},      64'(ov), 64'(ovf_m[k]));
    check({nm, ".new_best"}, 64'(nb), 64'(nb_m[k]));
  endtask

  task automatic check_all();
    check_inst(0, "A", 64'(bcd_a), 64'(bin_a), 64'(best_a), tick_a, ovf_a, nb_a);
    check_inst(1, "B", 64'(bcd_b), 64'(bin_b), 64'(best_b), tick_b, ovf_b, nb_b);
    check_inst(2, "C", 64'(bcd_c), 64'(bin_c), 64'(best_c), tick_c, ovf_c, nb_c);
  endtask

  task automatic cycle(input bit e, input bit c, input bit b);
    en = e; clr = c; bump = b;
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    @(negedge clk);
    if (tick_a) tick_cnt_a++;
    check_all();
  endtask

  initial begin
    int held_b;

    // Reset state
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b1;

    // Prescaled ticks: 31 enabled cycles give ticks after cycles 1, 16, 31
    tick_cnt_a = 0;
    repeat (31) cycle(1, 0, 0);
    check("A.ticks31", 64'(tick_cnt_a), 64'd3);
    check("A.bcd31", 64'(bcd_a), 64'h0003);
    check("A.bin31", 64'(bin_a), 64'd3);
    cycle(1, 0, 0);
    check("A.best_lag", 64'(best_a), 64'h0003);
    check("A.new_best_pulse", 64'(nb_a), 64'd1);

    // Tick and bump together at count 9: digit 0 carries straight to 0x0011
    cycle(1, 1, 0);
    cycle(1, 0, 0);
    repeat (8) cycle(1, 0, 1);
    check("A.at9", 64'(bcd_a), 64'h0009);
    repeat (6) cycle(1, 0, 0);
    cycle(1, 0, 1);
    check("A.tickbump", 64'(bcd_a), 64'h0011);
    check("A.tickbump_bin", 64'(bin_a), 64'd11);
    check("A.tickbump_tick", 64'(tick_a), 64'd1);

    // Disable: A clears, B holds, bump while disabled is ignored
    repeat (31) cycle(1, 0, 1);
    held_b = cnt_m[1];
    cycle(0, 0, 0);
    check("A.dis_clear", 64'(bcd_a), 64'h0000);
    check("B.dis_hold", 64'(bcd_b), to_bcd(held_b));
    cycle(0, 0, 1);
    check("B.dis_bump", 64'(bcd_b), to_bcd(held_b));
    check("A.best_kept", 64'(best_a), to_bcd(best_m[0]));
    cycle(1, 0, 0);
    check("A.reen_tick", 64'(tick_a), 64'd1);

    // Saturation (C) and wrap (B) with continuous bumps
    cycle(1, 1, 0);
    repeat (100) cycle(1, 0, 1);
    check("C.sat_bcd", 64'(bcd_c), 64'h99);
    check("C.sat_ovf", 64'(ovf_c), 64'd1);
    check("B.wrap_ovf", 64'(ovf_b), 64'd1);
    check("B.wrap_bcd", 64'(bcd_b), 64'h34);

    // clr beats en, bump and a due tick
    cycle(1, 1, 1);
    check("A.clr_bcd", 64'(bcd_a), 64'h0000);
    check("A.clr_tick", 64'(tick_a), 64'd0);
    check("C.clr_ovf", 64'(ovf_c), 64'd0);

    // Asynchronous reset mid-count
    repeat (50) cycle(1, 0, 1);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    check("A.async_rst_best", 64'(best_a), 64'h0000);
    cycle(1, 0, 1);
    rst = 1'b1;
    cycle(1, 0, 0);
    check("A.post_rst_nb", 64'(nb_a), 64'd0);

    // Randomised traffic
    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) begin
        #2 rst = 1'b0;
        #1 model_reset();
        check_all();
        cycle(1, 0, 0);
        rst = 1'b1;
      end
      cycle($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 30);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
